// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface divider_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 ovf;
  logic                 dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf, dbz
  );

endinterface

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift {r,q} left, subtract divisor if it fits.
module divider_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // r[WIDTH] is zero under the r < divisor invariant; folding it in keeps the step exact regardless.
  assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};
  assign fits    = r[WIDTH] | (shifted >= {1'b0, divisor});
  assign diff    = shifted - {1'b0, divisor};
  assign r_next  = fits ? diff : shifted;
  assign q_next  = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: 2*WIDTH / WIDTH -> WIDTH quotient and remainder in WIDTH cycles.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             accept_c;
  logic             dbz_c;
  logic             ovf_c;

  assign accept_c = bus.start && (state != RUN);
  assign dbz_c    = (bus.divisor == '0);
  assign ovf_c    = (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);

  divider_step #(.WIDTH(WIDTH)) u_step (
    .r       (r),
    .q       (q),
    .divisor (div_q),
    .r_next  (r_next),
    .q_next  (q_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      r             <= '0;
      q             <= '0;
      div_q         <= '0;
      count         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.ovf       <= 1'b0;
      bus.dbz       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            if (ovf_c) begin
              // Quotient cannot fit: saturate and report without iterating.
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.busy      <= 1'b0;
              bus.quotient  <= '1;
              bus.remainder <= '0;
              bus.ovf       <= 1'b1;
              bus.dbz       <= dbz_c;
            end else begin
              state    <= RUN;
              r        <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
              q        <= bus.dividend[WIDTH-1:0];
              div_q    <= bus.divisor;
              count    <= CW'(WIDTH);
              bus.busy <= 1'b1;
              bus.ovf  <= 1'b0;
              bus.dbz  <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r     <= r_next;
          q     <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= q_next;
            bus.remainder <= r_next[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed and randomised self-checking bench for the sequential divider.
module tb_divider;

  localparam int unsigned W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  divider_if #(.WIDTH(W)) bus ();

  divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for exactly one rising edge, then scramble operands.
  task automatic issue(input logic [31:0] dd, input logic [15:0] dv);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
  endtask

  // Count negedges until done is seen, giving up after 40.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < 40);
    if (!bus.done) cyc = -1;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.quotient !== 16'h0) begin errors++; $display("FAIL reset_quotient got %h want 0", bus.quotient); end
    checks++; if (bus.remainder !== 16'h0) begin errors++; $display("FAIL reset_remainder got %h want 0", bus.remainder); end
    checks++; if ({bus.ovf, bus.dbz} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus.ovf, bus.dbz}); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int busy_cnt;
    busy_cnt = 0;
    issue(32'd100000, 16'd7);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cnt++;
    end
    checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d want 16", busy_cnt); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_done_latency got done=%b busy=%b want 1 0", bus.done, bus.busy); end
    checks++; if (bus.quotient !== 16'd14285 || bus.remainder !== 16'd5) begin errors++; $display("FAIL basic_result got %0d r%0d want 14285 r5", bus.quotient, bus.remainder); end
    checks++; if ({bus.ovf, bus.dbz} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {bus.ovf, bus.dbz}); end
    repeat (3) @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.quotient !== 16'd14285 || bus.remainder !== 16'd5) begin errors++; $display("FAIL basic_hold got done=%b %0d r%0d want 0 14285 r5", bus.done, bus.quotient, bus.remainder); end
  endtask

  task automatic test_boundary;
    int cyc;
    issue(32'hFFFE0001, 16'hFFFF);
    wait_done(cyc);
    checks++; if (cyc !== 17) begin errors++; $display("FAIL boundary_latency got %0d want 17", cyc); end
    checks++; if (bus.quotient !== 16'hFFFF || bus.remainder !== 16'h0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL boundary_result got %h r%h ovf=%b want ffff r0000 ovf=0", bus.quotient, bus.remainder, bus.ovf); end
  endtask

  task automatic test_dbz;
    issue(32'h12345678, 16'h0);
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL dbz_early_done got done=%b busy=%b want 1 0", bus.done, bus.busy); end
    checks++; if ({bus.dbz, bus.ovf} !== 2'b11) begin errors++; $display("FAIL dbz_flags got dbz/ovf=%b want 11", {bus.dbz, bus.ovf}); end
    checks++; if (bus.quotient !== 16'hFFFF || bus.remainder !== 16'h0) begin errors++; $display("FAIL dbz_result got %h r%h want ffff r0000", bus.quotient, bus.remainder); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dbz_after got done=%b busy=%b want 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_ovf;
    issue(32'h00070000, 16'd7);
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL ovf_early_done got done=%b busy=%b want 1 0", bus.done, bus.busy); end
    checks++; if ({bus.ovf, bus.dbz} !== 2'b10) begin errors++; $display("FAIL ovf_flags got ovf/dbz=%b want 10", {bus.ovf, bus.dbz}); end
    checks++; if (bus.quotient !== 16'hFFFF || bus.remainder !== 16'h0) begin errors++; $display("FAIL ovf_result got %h r%h want ffff r0000", bus.quotient, bus.remainder); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(32'd100000, 16'd7);
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    checks++; if (cyc !== 12) begin errors++; $display("FAIL ignore_latency got %0d want 12", cyc); end
    checks++; if (bus.quotient !== 16'd14285 || bus.remainder !== 16'd5) begin errors++; $display("FAIL ignore_result got %0d r%0d want 14285 r5", bus.quotient, bus.remainder); end
    // Issue in the DONE cycle itself.
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 16'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc);
    checks++; if (cyc !== 17) begin errors++; $display("FAIL b2b_latency got %0d want 17", cyc); end
    checks++; if (bus.quotient !== 16'd16 || bus.remainder !== 16'd2 || bus.ovf !== 1'b0) begin errors++; $display("FAIL b2b_result got %0d r%0d ovf=%b want 16 r2 ovf=0", bus.quotient, bus.remainder, bus.ovf); end
  endtask

  task automatic test_mid_reset;
    int cyc;
    int done_seen;
    done_seen = 0;
    issue(32'd100000, 16'd7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done, bus.ovf, bus.dbz} !== 4'b0000 || bus.quotient !== 16'h0 || bus.remainder !== 16'h0) begin errors++; $display("FAIL midrst_outputs got busy=%b done=%b ovf=%b dbz=%b %h r%h want all zero", bus.busy, bus.done, bus.ovf, bus.dbz, bus.quotient, bus.remainder); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", done_seen); end
    issue(32'd9, 16'd2);
    wait_done(cyc);
    checks++; if (cyc !== 17 || bus.quotient !== 16'd4 || bus.remainder !== 16'd1) begin errors++; $display("FAIL midrst_after got cyc=%0d %0d r%0d want 17 4 r1", cyc, bus.quotient, bus.remainder); end
  endtask

  task automatic test_random;
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [31:0] dd;
    for (int i = 0; i < 200; i++) begin
      a  = 16'($urandom_range(0, 65535));
      b  = 16'($urandom_range(1, 65535));
      c  = (i % 2 == 0) ? 16'h0 : 16'($urandom_range(0, int'(b) - 1));
      dd = 32'(a) * 32'(b) + 32'(c);
      issue(dd, b);
      wait_done(cyc);
      checks++;
      if (cyc !== 17 || bus.quotient !== a || bus.remainder !== c || bus.ovf !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d %h/%h got cyc=%0d q=%h r=%h ovf=%b want 17 q=%h r=%h ovf=0",
                 i, dd, b, cyc, bus.quotient, bus.remainder, bus.ovf, a, c);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_dbz();
    test_ovf();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
